// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the RV32I pipeline stall/flush sequencer.
//   ctrl_state_e  : sequencer FSM states
//   ctrl_out_t    : bundle of PC / stage-register enables and bubble flushes
//   NOP_INSTR     : encoding loaded into a stage register as a bubble
//   OP_LOAD/STORE : opcodes that raise the MEM-stage data-memory request
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ERR      = 2'd2
  } ctrl_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_out_t;

  // Everything advances, nothing is killed.
  localparam ctrl_out_t CTRL_FLOW = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Whole pipeline frozen on the memory access; a bubble drains into WB.
  localparam ctrl_out_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1
  };

  localparam ctrl_out_t CTRL_OFF = '0;

  // Controls when no memory stall is pending: branch beats load hazard.
  function automatic ctrl_out_t resolve_ctrl(input logic br_taken, input logic load_hazard);
    ctrl_out_t c;
    c = CTRL_FLOW;
    if (br_taken) begin
      // Kill the two wrong-path instructions behind the branch.
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_hazard) begin
      // Hold PC and IF/ID, inject one bubble into EX.
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

  function automatic logic is_mem_opcode(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Request/control bundle between the pipeline datapath and the sequencer.
//   i_load_hazard, i_br_taken, i_mem_req, i_mem_ack : requests into sequencer
//   o_pc_en, o_*_en, o_*_flush                      : enables / bubble loads
//   o_mem_err, o_stall_cnt, o_redirect_cnt          : status and perf counters
// modport master: datapath side (drives requests)
// modport slave : sequencer side (drives controls)
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_load_hazard;
  logic             i_br_taken;
  logic             i_mem_req;
  logic             i_mem_ack;
  logic             o_pc_en;
  logic             o_IF_ID_en;
  logic             o_ID_EX_en;
  logic             o_EX_MEM_en;
  logic             o_MEM_WB_en;
  logic             o_IF_ID_flush;
  logic             o_ID_EX_flush;
  logic             o_MEM_WB_flush;
  logic             o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_redirect_cnt;

  modport master (
    output i_load_hazard, i_br_taken, i_mem_req, i_mem_ack,
    input  o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
    input  o_IF_ID_flush, o_ID_EX_flush, o_MEM_WB_flush,
    input  o_mem_err, o_stall_cnt, o_redirect_cnt
  );

  modport slave (
    input  i_load_hazard, i_br_taken, i_mem_req, i_mem_ack,
    output o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
    output o_IF_ID_flush, o_ID_EX_flush, o_MEM_WB_flush,
    output o_mem_err, o_stall_cnt, o_redirect_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// ---------------------------------------------------------------------------
// perf_counter
// Free-running event counter, wraps modulo 2^CNT_W.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_inc   : count this cycle
//   o_cnt   : current count
// ---------------------------------------------------------------------------
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_cnt = cnt_reg;
endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage RV32I pipeline. Merges the MEM-stage
// memory handshake, the EX redirect and the ID load-use hazard (in that
// priority) into PC/stage enables and bubble flushes, same cycle.
//   i_clk   : pipeline clock
//   i_rst_n : asynchronous active-low reset; all controls low while asserted
//   bus     : pipeline_ctrl_if.slave (requests in, controls/status out)
// Parameters:
//   MEM_TIMEOUT : max consecutive MEM_WAIT cycles before sticky error, 0 = off
//   CNT_W       : perf counter width
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pipeline_ctrl_if.slave bus
);
  localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic            TMO_ON     = (MEM_TIMEOUT != 0);

  ctrl_state_e       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_err_reg;
  ctrl_out_t         ctrl_out;
  logic              redirect_act;
  logic              stall_act;
  logic              mem_stall_run;

  // A request without a same-cycle ack is a multi-cycle access.
  assign mem_stall_run = bus.i_mem_req && !bus.i_mem_ack;

  // State register plus the registered wait counter and error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= CTRL_RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_reg | (state_next == CTRL_ERR);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    unique case (state_reg)
      CTRL_RUN: begin
        if (mem_stall_run) begin
          state_next    = CTRL_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else begin
          wait_cnt_next = '0;
        end
      end
      CTRL_MEM_WAIT: begin
        if (bus.i_mem_ack) begin
          state_next    = CTRL_RUN;
          wait_cnt_next = '0;
        end else if (TMO_ON && (wait_cnt_reg == WAIT_LIMIT)) begin
          state_next = CTRL_ERR;
        end else if (wait_cnt_reg != WAIT_MAX) begin
          // Saturates only when the timeout is disabled.
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      CTRL_ERR: begin
        state_next = CTRL_ERR;
      end
      default: begin
        state_next    = CTRL_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Mealy outputs. Reset level forces every control low.
  always_comb begin
    ctrl_out     = CTRL_OFF;
    redirect_act = 1'b0;
    if (i_rst_n) begin
      unique case (state_reg)
        CTRL_RUN: begin
          if (mem_stall_run) begin
            ctrl_out = CTRL_FREEZE;
          end else begin
            ctrl_out     = resolve_ctrl(bus.i_br_taken, bus.i_load_hazard);
            redirect_act = bus.i_br_taken;
          end
        end
        CTRL_MEM_WAIT: begin
          // The frozen upstream stages keep presenting their requests, so on
          // the ack cycle they are resolved just as in RUN.
          if (!bus.i_mem_ack) begin
            ctrl_out = CTRL_FREEZE;
          end else begin
            ctrl_out     = resolve_ctrl(bus.i_br_taken, bus.i_load_hazard);
            redirect_act = bus.i_br_taken;
          end
        end
        default: begin
          ctrl_out = CTRL_OFF;
        end
      endcase
    end
  end

  // Stall cycles are only those the sequencer chooses; ERR is not counted.
  assign stall_act = i_rst_n && (state_reg != CTRL_ERR) && !ctrl_out.pc_en;

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {redirect_act, stall_act};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      perf_counter #(
        .CNT_W (CNT_W)
      ) u_perf_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (cnt_inc[gi]),
        .o_cnt   (cnt_val[gi])
      );
    end
  endgenerate

  assign bus.o_pc_en          = ctrl_out.pc_en;
  assign bus.o_IF_ID_en       = ctrl_out.if_id_en;
  assign bus.o_ID_EX_en       = ctrl_out.id_ex_en;
  assign bus.o_EX_MEM_en      = ctrl_out.ex_mem_en;
  assign bus.o_MEM_WB_en      = ctrl_out.mem_wb_en;
  assign bus.o_IF_ID_flush    = ctrl_out.if_id_flush;
  assign bus.o_ID_EX_flush    = ctrl_out.id_ex_flush;
  assign bus.o_MEM_WB_flush   = ctrl_out.mem_wb_flush;
  assign bus.o_mem_err        = mem_err_reg;
  assign bus.o_stall_cnt      = cnt_val[0];
  assign bus.o_redirect_cnt   = cnt_val[1];
endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: a directed vector table, hand-written
// reset/timeout sequences, then random stimulus against a cycle-level model.
// Control vector bit order: {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
//                            IF_ID_flush, ID_EX_flush, MEM_WB_flush}
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 32;

  localparam logic [7:0] E_NORM = 8'b11111_000;
  localparam logic [7:0] E_LOAD = 8'b00111_010;
  localparam logic [7:0] E_BR   = 8'b11111_110;
  localparam logic [7:0] E_FRZ  = 8'b00000_001;
  localparam logic [7:0] E_OFF  = 8'b00000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] got_ctrl;
  assign got_ctrl = {bus.o_pc_en, bus.o_IF_ID_en, bus.o_ID_EX_en, bus.o_EX_MEM_en,
                     bus.o_MEM_WB_en, bus.o_IF_ID_flush, bus.o_ID_EX_flush, bus.o_MEM_WB_flush};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts consecutive frozen cycles of one access.
  int          m_pending;
  bit          m_err;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_redir;

  task automatic model_reset();
    m_pending = 0;
    m_err     = 1'b0;
    m_stall   = '0;
    m_redir   = '0;
  endtask

  task automatic drive(input bit req, input bit ack, input bit br, input bit ld);
    bus.i_mem_req     = req;
    bus.i_mem_ack     = ack;
    bus.i_br_taken    = br;
    bus.i_load_hazard = ld;
  endtask

  task automatic check(input string nm, input logic [7:0] ec, input logic [CW-1:0] es,
                       input logic [CW-1:0] er, input logic ee);
    // ID_EX enable is irrelevant when a bubble is forced into ID/EX.
    logic [7:0] m;
    m = ec[1] ? 8'b1101_1111 : 8'hFF;
    n_cmp++;
    if ((got_ctrl & m) !== (ec & m)) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want %b", nm, got_ctrl, ec);
    end
    n_cmp++;
    if (bus.o_stall_cnt !== es) begin
      n_bad++;
      $display("FAIL %s stall_cnt: got %0d want %0d", nm, bus.o_stall_cnt, es);
    end
    n_cmp++;
    if (bus.o_redirect_cnt !== er) begin
      n_bad++;
      $display("FAIL %s redirect_cnt: got %0d want %0d", nm, bus.o_redirect_cnt, er);
    end
    n_cmp++;
    if (bus.o_mem_err !== ee) begin
      n_bad++;
      $display("FAIL %s mem_err: got %b want %b", nm, bus.o_mem_err, ee);
    end
    $display("%s req=%0d ack=%0d br=%0d ld=%0d ctrl=%b stall=%0d redir=%0d err=%0b",
             nm, bus.i_mem_req, bus.i_mem_ack, bus.i_br_taken, bus.i_load_hazard,
             got_ctrl, bus.o_stall_cnt, bus.o_redirect_cnt, bus.o_mem_err);
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic cyc(input string nm, input bit req, input bit ack, input bit br, input bit ld,
                     input logic [7:0] ec, input int es, input int er, input logic ee);
    drive(req, ack, br, ld);
    #2;
    check(nm, ec, CW'(es), CW'(er), ee);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("reset", E_OFF, '0, '0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    check("reset_busy_inputs", E_OFF, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        req;
    logic        ack;
    logic        br;
    logic        ld;
    logic [7:0]  ec;
    logic [31:0] es;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [17];

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    bit r_req, r_ack, r_br, r_ld;
    logic [7:0] r_ec;
    bit r_frozen;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd0, 32'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, E_LOAD, 32'd0, 32'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd1, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, E_BR,   32'd1, 32'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd1, 32'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, E_FRZ,  32'd1, 32'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, E_FRZ,  32'd2, 32'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, E_NORM, 32'd3, 32'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd3, 32'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, E_NORM, 32'd3, 32'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd3, 32'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, E_FRZ,  32'd3, 32'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, E_BR,   32'd4, 32'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd4, 32'd2, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, E_FRZ,  32'd4, 32'd2, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, E_LOAD, 32'd5, 32'd2, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 32'd6, 32'd2, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].req, tbl[i].ack, tbl[i].br, tbl[i].ld,
          tbl[i].ec, int'(tbl[i].es), int'(tbl[i].er), tbl[i].ee);
    end

    // Reset in the middle of a memory wait.
    cyc("midwait0", 1, 0, 0, 0, E_FRZ, 6, 2, 0);
    cyc("midwait1", 1, 0, 0, 0, E_FRZ, 7, 2, 0);
    cyc("midwait2", 1, 0, 0, 0, E_FRZ, 8, 2, 0);
    #1 rst_n = 1'b0;
    #1 check("midwait_rst", E_OFF, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("stale_ack", 0, 1, 0, 0, E_NORM, 0, 0, 0);

    // Full timeout from a cleared wait counter: 1 RUN + 4 MEM_WAIT frozen cycles.
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("tmo_wait%0d", i), 1, 0, 0, 0, E_FRZ, i, 0, 0);
    end
    cyc("tmo_err",   1, 0, 0, 0, E_OFF, 5, 0, 1);
    cyc("err_hold",  1, 1, 1, 1, E_OFF, 5, 0, 1);
    cyc("err_hold2", 0, 1, 0, 0, E_OFF, 5, 0, 1);
    #3 rst_n = 1'b0;
    #1 check("err_async_rst", E_OFF, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_err_rst", 0, 0, 0, 0, E_NORM, 0, 0, 0);

    // Random stimulus against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      r_req = ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 1) == 0);
      r_br  = ($urandom_range(0, 3) == 0);
      r_ld  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
        drive(r_req, r_ack, r_br, r_ld);
        rst_n = 1'b0;
        #2;
        check("rnd_rst", E_OFF, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end else begin
        drive(r_req, r_ack, r_br, r_ld);
        #2;
        r_frozen = 1'b0;
        if (m_err) begin
          r_ec = E_OFF;
        end else if ((m_pending > 0 || r_req) && !r_ack) begin
          r_ec     = E_FRZ;
          r_frozen = 1'b1;
        end else if (r_br) begin
          r_ec = E_BR;
        end else if (r_ld) begin
          r_ec = E_LOAD;
        end else begin
          r_ec = E_NORM;
        end
        check($sformatf("rnd%0d", n), r_ec, m_stall, m_redir, m_err);
        if (!m_err) begin
          if (r_ec[7] == 1'b0) m_stall = m_stall + 1'b1;
          if (r_ec == E_BR)    m_redir = m_redir + 1'b1;
          if (r_frozen) begin
            m_pending++;
            if (m_pending == TMO + 1) m_err = 1'b1;
          end else begin
            m_pending = 0;
          end
        end
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. Combines three requests into per-stage register enables, per-stage bubble insertion and the PC enable:
- the ID-stage load-use hazard flag;
- the EX-stage branch/jump redirect;
- the MEM-stage data-memory handshake.

A small FSM tracks multi-cycle memory waits with a timeout and a sticky error flag. Two 32-bit performance counters record stall cycles and redirects.

## Interface
- MEM_TIMEOUT, 255: max consecutive MEM_WAIT cycles before error; 0 disables the timeout.
- CNT_W, 32: performance counter width.
- i_clk  in  1  pipeline clock. Reset is asynchronous, active-low.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load_hazard  in  1  load-use hazard between EX load rd and ID rs1/rs2 (comb, ID stage).
- i_br_taken  in  1  EX-stage redirect (taken branch, jal, jalr); PC mux already selects target.
- i_mem_req  in  1  MEM-stage instruction is a load/store needing the data memory.
- i_mem_ack  in  1  data memory completes the access this cycle.
- o_pc_en  out  1  PC register load enable.
- o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en  out  1 each  pipeline register enables.
- o_IF_ID_flush, o_ID_EX_flush, o_MEM_WB_flush  out  1 each  load a NOP/bubble into that register (wins over its enable).
- o_mem_err  out  1  sticky memory timeout error.
- o_stall_cnt  out  CNT_W  cycles with o_pc_en=0 outside reset and ERR.
- o_redirect_cnt  out  CNT_W  accepted redirects.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- Outputs are Mealy (combinational from state and inputs). Counters, the wait counter and o_mem_err are registered.
- In RUN, requests are taken in priority order (mem > branch > load):
  - i_mem_req && !i_mem_ack:
    - outputs: pc_en=0; IF_ID/ID_EX/EX_MEM/MEM_WB enables=0; MEM_WB_flush=1; all other flushes=0.
    - next state MEM_WAIT; wait_cnt<=1.
    - Branch and load requests are ignored; they are re-presented because the upstream stages are frozen.
  - else i_br_taken: all enables=1; IF_ID_flush=1; ID_EX_flush=1. i_load_hazard is ignored because the ID instruction is killed.
  - else i_load_hazard: pc_en=0; IF_ID_en=0; ID_EX_flush=1; EX_MEM and MEM_WB advance.
  - else: all enables=1, all flushes=0.
- MEM_WAIT:
  - !i_mem_ack: same outputs as the RUN mem-stall case; wait_cnt++.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT with no ack: next state ERR.
  - i_mem_ack: outputs evaluated exactly as RUN with the mem request treated as satisfied (branch/load priority applies); next state RUN; wait_cnt<=0.
- ERR: all enables=0, all flushes=0, o_mem_err=1. Only reset leaves ERR.
- Counters:
  - o_stall_cnt increments on every cycle with o_pc_en=0 in RUN/MEM_WAIT.
  - o_redirect_cnt increments on every cycle where the i_br_taken branch is acted on.
  - Both wrap modulo 2^CNT_W.
- Width rule: wait_cnt is $clog2(MEM_TIMEOUT+1) bits minimum 1 and never wraps (bounded by the timeout; held at max when the timeout is disabled).

## Timing
- Zero-cycle latency from request inputs to enable/flush outputs (same cycle). State takes effect next edge.
- Single-cycle memory (i_mem_ack with i_mem_req in the same cycle) costs no stall and never enters MEM_WAIT.
- An N-cycle memory (ack in the N-th cycle after the first request) freezes the pipeline for N cycles; the PC advances on the ack cycle.
- A load hazard costs exactly one bubble. A redirect costs two bubbles (IF/ID and ID/EX).
- Simultaneous mem stall and branch: the branch is acted on in the ack cycle. Simultaneous branch and load hazard: branch only, no stall counted.
- Reset (async assert, any state, including mid-MEM_WAIT or ERR):
  - state=RUN, wait_cnt=0, counters=0, o_mem_err=0.
  - While i_rst_n=0: all enables=0, all flushes=0.
  - First cycle after deassert: outputs follow the RUN rules.

## Structure
- Package ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_e {CTRL_RUN, CTRL_MEM_WAIT, CTRL_ERR};
  - the NOP encoding 32'h0000_0013 used by the stage registers for bubbles;
  - the opcode constants OP_LOAD=7'h03 and OP_STORE=7'h23 used to generate i_mem_req upstream.
- One sub-module, perf_counter (CNT_W, i_clk, i_rst_n, i_inc, o_cnt), instantiated twice.

## Test plan
- Reset with all inputs 0 -> all enables=0 and flushes=0 during reset. First post-reset cycle: all enables=1, counters 0, o_mem_err=0.
- i_load_hazard=1 for one cycle -> pc_en=0, IF_ID_en=0, ID_EX_flush=1, EX_MEM_en=1; o_stall_cnt=1; next cycle all enables=1.
- i_br_taken=1 together with i_load_hazard=1 -> IF_ID_flush=1, ID_EX_flush=1, pc_en=1; o_redirect_cnt=1, o_stall_cnt=0.
- i_mem_req=1, i_mem_ack after 3 cycles (ack in cycle 3):
  - cycles 1-2: pipeline frozen, MEM_WB_flush=1;
  - cycle 3: released;
  - o_stall_cnt=2; state back to RUN.
- MEM_TIMEOUT=4, i_mem_req=1, no ack -> ERR after the 4th wait cycle; o_mem_err=1 held; all enables 0; async reset clears it.
- Reset asserted mid-MEM_WAIT -> immediate RUN and counters 0; stale i_mem_ack after deassert causes no state change.
